// File: rtl/goose_anim_pkg.sv
// rtl/goose_anim_pkg.sv - state, direction and spin-sequence definitions shared by goose_anim_ctrl
package goose_anim_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   localparam logic [1:0] ST_WALK_R = 2'd0;
   localparam logic [1:0] ST_WALK_L = 2'd1;
   localparam logic [1:0] ST_SPIN   = 2'd2;

   typedef enum logic [1:0] {
      WALK_R = ST_WALK_R,
      WALK_L = ST_WALK_L,
      SPIN   = ST_SPIN
   } state_e;

   typedef enum logic {
      DIR_R = 1'b0,
      DIR_L = 1'b1
   } dir_e;

   // Frame shown after each spin step, packed LSB-first: {0,2,3,1}.
   localparam logic [7:0] SPIN_SEQ = {2'd1, 2'd3, 2'd2, 2'd0};

   function automatic logic [1:0] spin_frame(input logic [1:0] step);
      return SPIN_SEQ[{step, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/sprite_window.sv
// rtl/sprite_window.sv - registered sprite hit test and cell-coordinate generator
module sprite_window
   import goose_anim_pkg::*;
#(
   parameter int SPRITE_CELLS = 25,
   parameter int SCALE_SHIFT  = 3,
   parameter int Y_POS        = 50
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [9:0] pix_x_i,
   input  logic [9:0] pix_y_i,
   input  logic       display_on_i,
   input  logic [9:0] spr_x_i,
   output logic [4:0] cell_x_o,
   output logic [4:0] cell_y_o,
   output logic       in_sprite_o
);

   localparam logic [9:0] SPAN  = 10'(SPRITE_CELLS << SCALE_SHIFT);
   localparam logic [9:0] Y_TOP = 10'(Y_POS);

   logic [9:0] rel_x, rel_y;
   logic       hit;
   logic [4:0] cell_x_q, cell_y_q;
   logic       in_sprite_q;

   // 10-bit wraparound; the >= guards reject pixels left of / above the box.
   assign rel_x = pix_x_i - spr_x_i;
   assign rel_y = pix_y_i - Y_TOP;
   assign hit   = display_on_i && (pix_x_i >= spr_x_i) && (pix_y_i >= Y_TOP)
                  && (rel_x < SPAN) && (rel_y < SPAN);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cell_x_q    <= '0;
         cell_y_q    <= '0;
         in_sprite_q <= 1'b0;
      end else begin
         in_sprite_q <= hit;
         cell_x_q    <= hit ? rel_x[SCALE_SHIFT +: 5] : 5'd0;
         cell_y_q    <= hit ? rel_y[SCALE_SHIFT +: 5] : 5'd0;
      end
   end

   assign cell_x_o    = cell_x_q;
   assign cell_y_o    = cell_y_q;
   assign in_sprite_o = in_sprite_q;

endmodule

// File: rtl/goose_anim_ctrl.sv
// rtl/goose_anim_ctrl.sv - goose walk/spin sequencer and sprite window; GOOSE_ANIM_PAUSE_EN adds a pause input
module goose_anim_ctrl
   import goose_anim_pkg::*;
#(
   parameter int SPRITE_CELLS    = 25,
   parameter int SCALE_SHIFT     = 3,
   parameter int X_MIN           = 0,
   parameter int X_MAX           = H_ACTIVE - (SPRITE_CELLS << SCALE_SHIFT),
   parameter int Y_POS           = 50,
   parameter int STEP_PX         = 2,
   parameter int FRAMES_PER_STEP = 4,
   parameter int SPIN_LOOPS      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       display_on,
`ifdef GOOSE_ANIM_PAUSE_EN
   input  logic       pause,
`endif
   output logic [4:0] cell_x,
   output logic [4:0] cell_y,
   output logic       in_sprite,
   output logic [1:0] frame_sel,
   output logic [6:0] frame_counter
);

   localparam int SUB_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int LOOP_W = (SPIN_LOOPS > 1) ? $clog2(SPIN_LOOPS) : 1;

   localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(FRAMES_PER_STEP - 1);
   localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(SPIN_LOOPS - 1);
   localparam logic [10:0]       STEP_11   = 11'(STEP_PX);
   localparam logic [10:0]       X_MIN_11  = 11'(X_MIN);
   localparam logic [10:0]       X_MAX_11  = 11'(X_MAX);
   localparam logic [9:0]        X_MIN_10  = 10'(X_MIN);
   localparam logic [9:0]        X_MAX_10  = 10'(X_MAX);

   logic              fs, anim_hold;
   logic [1:0]        state_q, state_d;
   dir_e              dir_q, dir_d;
   logic [9:0]        spr_x_q, spr_x_d;
   logic [SUB_W-1:0]  sub_q, sub_d;
   logic [1:0]        step_q, step_d;
   logic [LOOP_W-1:0] loop_q, loop_d;
   logic [1:0]        frame_sel_q, frame_sel_d;
   logic [6:0]        frame_cnt_q;
   logic [10:0]       x_inc, x_dec;

   assign fs = (pix_x == 10'd0) && (pix_y == 10'd0);

`ifdef GOOSE_ANIM_PAUSE_EN
   assign anim_hold = pause;
`else
   assign anim_hold = 1'b0;
`endif

   // 11-bit headroom keeps the saturating add/subtract free of wrap.
   assign x_inc = {1'b0, spr_x_q} + STEP_11;
   assign x_dec = {1'b0, spr_x_q} - STEP_11;

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      spr_x_d     = spr_x_q;
      sub_d       = sub_q;
      step_d      = step_q;
      loop_d      = loop_q;
      frame_sel_d = frame_sel_q;
      case (state_q)
         ST_WALK_R: begin
            frame_sel_d = 2'd3;
            spr_x_d     = (x_inc > X_MAX_11) ? X_MAX_10 : x_inc[9:0];
            if (spr_x_q == X_MAX_10) begin
               state_d = ST_SPIN;
               dir_d   = DIR_L;
            end
         end
         ST_WALK_L: begin
            frame_sel_d = 2'd0;
            spr_x_d     = ({1'b0, spr_x_q} < (X_MIN_11 + STEP_11)) ? X_MIN_10 : x_dec[9:0];
            if (spr_x_q == X_MIN_10) begin
               state_d = ST_SPIN;
               dir_d   = DIR_R;
            end
         end
         ST_SPIN: begin
            if (sub_q == SUB_LAST) begin
               sub_d       = '0;
               step_d      = step_q + 2'd1;
               frame_sel_d = spin_frame(step_q);
               if (step_q == 2'd3) begin
                  if (loop_q == LOOP_LAST) begin
                     loop_d  = '0;
                     state_d = (dir_q == DIR_L) ? ST_WALK_L : ST_WALK_R;
                  end else begin
                     loop_d = loop_q + LOOP_W'(1);
                  end
               end
            end else begin
               sub_d = sub_q + SUB_W'(1);
            end
         end
         default: state_d = ST_WALK_R;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_WALK_R;
         dir_q       <= DIR_L;
         spr_x_q     <= X_MIN_10;
         sub_q       <= '0;
         step_q      <= 2'd0;
         loop_q      <= '0;
         frame_sel_q <= 2'd3;
         frame_cnt_q <= 7'd0;
      end else if (fs) begin
         frame_cnt_q <= frame_cnt_q + 7'd1;
         if (!anim_hold) begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            spr_x_q     <= spr_x_d;
            sub_q       <= sub_d;
            step_q      <= step_d;
            loop_q      <= loop_d;
            frame_sel_q <= frame_sel_d;
         end
      end
   end

   assign frame_sel     = frame_sel_q;
   assign frame_counter = frame_cnt_q;

   sprite_window #(
      .SPRITE_CELLS (SPRITE_CELLS),
      .SCALE_SHIFT  (SCALE_SHIFT),
      .Y_POS        (Y_POS)
   ) u_window (
      .clk_i        (clk),
      .reset_i      (reset),
      .pix_x_i      (pix_x),
      .pix_y_i      (pix_y),
      .display_on_i (display_on),
      .spr_x_i      (spr_x_q),
      .cell_x_o     (cell_x),
      .cell_y_o     (cell_y),
      .in_sprite_o  (in_sprite)
   );

endmodule

// File: tb/tb_goose_anim_ctrl.sv
// tb/tb_goose_anim_ctrl.sv - directed self-checking bench for goose_anim_ctrl
module tb_goose_anim_ctrl;
   import goose_anim_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] pix_x, pix_y;
   logic       display_on;
`ifdef GOOSE_ANIM_PAUSE_EN
   logic       pause;
`endif
   logic [4:0] cell_x, cell_y;
   logic       in_sprite;
   logic [1:0] frame_sel;
   logic [6:0] frame_counter;
   logic [4:0] cx3, cy3;
   logic       in3;
   logic [1:0] fsel3;
   logic [6:0] fc3;

   int n_cmp = 0;
   int n_bad = 0;
   int fs_cnt = 0;

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       disp;
      logic       exp_in;
      logic [4:0] exp_cx;
      logic [4:0] exp_cy;
   } hit_vec_t;

   hit_vec_t vecs[11];
   int       spin_seq[4] = '{0, 2, 3, 1};

   always #5 clk = ~clk;

   goose_anim_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .display_on    (display_on),
`ifdef GOOSE_ANIM_PAUSE_EN
      .pause         (pause),
`endif
      .cell_x        (cell_x),
      .cell_y        (cell_y),
      .in_sprite     (in_sprite),
      .frame_sel     (frame_sel),
      .frame_counter (frame_counter)
   );

   // Odd step: 438 + 3 must clamp to 440 rather than overshoot.
   goose_anim_ctrl #(.STEP_PX(3)) dut3 (
      .clk           (clk),
      .reset         (reset),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .display_on    (display_on),
`ifdef GOOSE_ANIM_PAUSE_EN
      .pause         (1'b0),
`endif
      .cell_x        (cx3),
      .cell_y        (cy3),
      .in_sprite     (in3),
      .frame_sel     (fsel3),
      .frame_counter (fc3)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      pix_x = 10'd0;
      pix_y = 10'd0;
      tick();
      pix_x = 10'd1;
      tick();
      fs_cnt++;
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic chk_anim(input string tag, input int st, input int sx, input int fsel);
      chk({tag, " state"}, int'(dut.state_q), st);
      chk({tag, " spr_x"}, int'(dut.spr_x_q), sx);
      chk({tag, " frame_sel"}, int'(frame_sel), fsel);
      chk({tag, " frame_counter"}, int'(frame_counter), fs_cnt % 128);
   endtask

   initial begin
      vecs[0]  = '{10'd100, 10'd50,  1'b1, 1'b1, 5'd0,  5'd0};
      vecs[1]  = '{10'd299, 10'd249, 1'b1, 1'b1, 5'd24, 5'd24};
      vecs[2]  = '{10'd300, 10'd50,  1'b1, 1'b0, 5'd0,  5'd0};
      vecs[3]  = '{10'd99,  10'd50,  1'b1, 1'b0, 5'd0,  5'd0};
      vecs[4]  = '{10'd100, 10'd49,  1'b1, 1'b0, 5'd0,  5'd0};
      vecs[5]  = '{10'd150, 10'd100, 1'b0, 1'b0, 5'd0,  5'd0};
      vecs[6]  = '{10'd150, 10'd100, 1'b1, 1'b1, 5'd6,  5'd6};
      vecs[7]  = '{10'd107, 10'd57,  1'b1, 1'b1, 5'd0,  5'd0};
      vecs[8]  = '{10'd108, 10'd58,  1'b1, 1'b1, 5'd1,  5'd1};
      vecs[9]  = '{10'd299, 10'd250, 1'b1, 1'b0, 5'd0,  5'd0};
      vecs[10] = '{10'd1000, 10'd60, 1'b1, 1'b0, 5'd0,  5'd0};

      reset      = 1'b1;
      pix_x      = 10'd110;
      pix_y      = 10'd60;
      display_on = 1'b1;
`ifdef GOOSE_ANIM_PAUSE_EN
      pause      = 1'b0;
`endif
      tick();
      tick();
      chk("reset in_sprite", int'(in_sprite), 0);
      chk("reset cell_x", int'(cell_x), 0);
      chk("reset cell_y", int'(cell_y), 0);
      chk_anim("reset", int'(ST_WALK_R), 0, 3);
      reset = 1'b0;
      pix_x = 10'd1;
      pix_y = 10'd0;

      for (int k = 1; k <= 5; k++) begin
         frame();
         chk_anim("walk5", int'(ST_WALK_R), 2 * k, 3);
      end

      run_frames(45);
      chk("spr_x at fs50", int'(dut.spr_x_q), 100);
      for (int i = 0; i < 11; i++) begin
         pix_x      = vecs[i].px;
         pix_y      = vecs[i].py;
         display_on = vecs[i].disp;
         tick();
         chk($sformatf("hit[%0d] in_sprite", i), int'(in_sprite), int'(vecs[i].exp_in));
         chk($sformatf("hit[%0d] cell_x", i), int'(cell_x), int'(vecs[i].exp_cx));
         chk($sformatf("hit[%0d] cell_y", i), int'(cell_y), int'(vecs[i].exp_cy));
      end
      display_on = 1'b1;

      run_frames(96);
      chk("step3 spr_x fs146", int'(dut3.spr_x_q), 438);
      frame();
      chk("step3 sat spr_x", int'(dut3.spr_x_q), 440);
      chk("step3 state fs147", int'(dut3.state_q), int'(ST_WALK_R));
      frame();
      chk("step3 spin state", int'(dut3.state_q), int'(ST_SPIN));
      chk("step3 spin spr_x", int'(dut3.spr_x_q), 440);
      chk("main spr_x fs148", int'(dut.spr_x_q), 296);

      run_frames(72);
      chk_anim("edge fs220", int'(ST_WALK_R), 440, 3);
      frame();
      chk_anim("spin entry", int'(ST_SPIN), 440, 3);

      for (int k = 1; k <= 64; k++) begin
         frame();
         if (k % 4 == 0)
            chk($sformatf("spin k=%0d frame_sel", k), int'(frame_sel), spin_seq[(k / 4 - 1) % 4]);
         if (k == 63) chk_anim("spin k=63", int'(ST_SPIN), 440, 3);
         if (k == 64) chk("spin k=64 state", int'(dut.state_q), int'(ST_WALK_L));
      end
      frame();
      chk_anim("walk_l first", int'(ST_WALK_L), 438, 0);

      reset = 1'b1;
      pix_x = 10'd5;
      pix_y = 10'd5;
      tick();
      reset  = 1'b0;
      fs_cnt = 0;
      run_frames(231);
      chk_anim("mid spin", int'(ST_SPIN), 440, 2);
      reset = 1'b1;
      pix_x = 10'd5;
      pix_y = 10'd5;
      tick();
      fs_cnt = 0;
      chk_anim("reset mid spin", int'(ST_WALK_R), 0, 3);
      reset = 1'b0;
      pix_x = 10'd1;
      pix_y = 10'd0;

`ifdef GOOSE_ANIM_PAUSE_EN
      run_frames(3);
      pause = 1'b1;
      run_frames(10);
      chk_anim("paused", int'(ST_WALK_R), 6, 3);
      pause = 1'b0;
      frame();
      chk_anim("unpaused", int'(ST_WALK_R), 8, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
